// File: rtl/piso_serializer.sv
// =============================================================================
// Module      : piso_serializer
// Description : Parallel-in / serial-out stage feeding the serial sequence
//               detectors. Accepts WIDTH-bit words on a valid/ready handshake
//               and shifts them out MSB-first, one bit per clock, with an
//               optional forced idle gap between words and an optional even
//               parity bit appended after the data bits.
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
// Parameters
//   WIDTH       word width, >= 2
//   GAP_CYCLES  idle cycles forced between words (0..255); 0 enables
//               back-to-back words with no bubble
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   in_data    in   WIDTH  parallel word, sampled on handshake
//   in_valid   in   1      upstream word available
//   in_ready   out  1      block can accept (handshake = in_valid & in_ready)
//   ser_bit    out  1      serial data, MSB first (registered)
//   ser_valid  out  1      ser_bit carries a payload bit (registered)
//   word_done  out  1      1-cycle pulse on the last serial bit of a word
//   busy       out  1      serializer is not idle
// Configuration macro
//   SER_PARITY_EN  when defined, each word is followed by one even-parity
//                  bit (WIDTH+1 serial bits per word). Undefined by default.
// =============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int              CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit              HAS_GAP     = (GAP_CYCLES > 0);
    localparam logic [7:0]      GAP_LAST    = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       gap_q,       gap_d;
    logic             ser_bit_q,   ser_bit_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
    logic             parity_q,    parity_d;
`endif

    logic last_cycle;
    logic can_accept;
    logic handshake;

    // -------------------------------------------------------------------------
    // Handshake
    // The last output cycle of a word is the final data bit, or the parity
    // bit when parity is enabled. With no forced gap the block accepts the
    // next word during that cycle so the bitstream stays contiguous.
    // -------------------------------------------------------------------------
`ifdef SER_PARITY_EN
    assign last_cycle = (state_q == ST_PAR);
`else
    assign last_cycle = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
`endif

    assign can_accept = (state_q == ST_IDLE) || (!HAS_GAP && last_cycle);

    // Gated by rst so upstream sees no readiness while reset is asserted.
    assign in_ready  = rst & can_accept;
    assign handshake = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // Output flops are loaded with the value that must appear in the cycle
    // after the edge, so ser_bit/ser_valid/word_done are clean registers.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        ser_bit_d   = 1'b0;
        ser_valid_d = 1'b0;
        word_done_d = 1'b0;
`ifdef SER_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Loading is handled by the common handshake branch below.
            end

            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    // Present the next data bit; the current MSB has been sent.
                    cnt_d       = cnt_q + CNT_ONE;
                    shift_d     = {shift_q[WIDTH-2:0], 1'b0};
                    ser_bit_d   = shift_q[WIDTH-2];
                    ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    word_done_d = 1'b0;
`else
                    word_done_d = (cnt_q == CNT_PENULT);
`endif
                end else begin
`ifdef SER_PARITY_EN
                    // Data bits exhausted: follow with the parity bit.
                    state_d     = ST_PAR;
                    shift_d     = '0;
                    ser_bit_d   = parity_q;
                    ser_valid_d = 1'b1;
                    word_done_d = 1'b1;
`else
                    state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                    gap_d   = 8'd0;
`endif
                end
            end

`ifdef SER_PARITY_EN
            ST_PAR: begin
                state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                cnt_d   = '0;
                gap_d   = 8'd0;
            end
`endif

            ST_GAP: begin
                // Gap counter runs 0..GAP_CYCLES-1 and wraps back to zero.
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
                gap_d   = 8'd0;
            end
        endcase

        // A handshake (in IDLE, or in the last output cycle when no gap is
        // configured) overrides the end-of-word transition and starts the new
        // word immediately, presenting its MSB in the next cycle.
        if (handshake) begin
            state_d     = ST_SHIFT;
            shift_d     = in_data;
            cnt_d       = '0;
            gap_d       = 8'd0;
            ser_bit_d   = in_data[WIDTH-1];
            ser_valid_d = 1'b1;
            word_done_d = 1'b0;
`ifdef SER_PARITY_EN
            parity_d    = ^in_data;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= 8'd0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// =============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Three instances with
//               different WIDTH/GAP_CYCLES share one stimulus stream and are
//               compared cycle by cycle against a frame-position model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_piso_serializer;

    localparam int ND = 3;
    localparam int W0 = 8, G0 = 0;
    localparam int W1 = 8, G1 = 2;
    localparam int W2 = 3, G2 = 1;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB0 = W0 + PB;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_valid = 1'b0;
    logic [ND-1:0] o_ready, o_bit, o_valid, o_done, o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W0), .GAP_CYCLES(G0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data[W0-1:0]), .in_valid(in_valid),
        .in_ready(o_ready[0]), .ser_bit(o_bit[0]), .ser_valid(o_valid[0]),
        .word_done(o_done[0]), .busy(o_busy[0]));

    piso_serializer #(.WIDTH(W1), .GAP_CYCLES(G1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data[W1-1:0]), .in_valid(in_valid),
        .in_ready(o_ready[1]), .ser_bit(o_bit[1]), .ser_valid(o_valid[1]),
        .word_done(o_done[1]), .busy(o_busy[1]));

    piso_serializer #(.WIDTH(W2), .GAP_CYCLES(G2)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data[W2-1:0]), .in_valid(in_valid),
        .in_ready(o_ready[2]), .ser_bit(o_bit[2]), .ser_valid(o_valid[2]),
        .word_done(o_done[2]), .busy(o_busy[2]));

    // -------------------------------------------------------------------------
    // Reference model: each word occupies a frame of (W+PB) serial bits then
    // G silent cycles. m_pos is the position inside the frame, -1 when idle.
    // -------------------------------------------------------------------------
    int         m_pos [ND] = '{-1, -1, -1};
    logic [7:0] m_word[ND] = '{8'h00, 8'h00, 8'h00};
    int         m_hs  [ND] = '{0, 0, 0};

    function automatic int wid(int i);
        return (i == 0) ? W0 : (i == 1) ? W1 : W2;
    endfunction

    function automatic int gapn(int i);
        return (i == 0) ? G0 : (i == 1) ? G1 : G2;
    endfunction

    function automatic int nbits(int i);
        return wid(i) + PB;
    endfunction

    function automatic logic model_ready(int i);
        return (m_pos[i] < 0) || (gapn(i) == 0 && m_pos[i] == nbits(i) - 1);
    endfunction

    // Expected {in_ready, ser_bit, ser_valid, word_done, busy}
    function automatic logic [4:0] expv(int i);
        logic r, b, v, d, bz;
        int   p;
        p  = m_pos[i];
        r  = rst && model_ready(i);
        v  = (p >= 0) && (p < nbits(i));
        b  = 1'b0;
        if (p >= 0 && p < wid(i)) b = m_word[i][wid(i) - 1 - p];
        else if (v)               b = ^m_word[i];
        d  = (p >= 0) && (p == nbits(i) - 1);
        bz = (p >= 0);
        return {r, b, v, d, bz};
    endfunction

    function automatic logic [4:0] obs(int i);
        return {o_ready[i], o_bit[i], o_valid[i], o_done[i], o_busy[i]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ND; i++) m_pos[i] = -1;
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (in_valid && model_ready(i)) begin
                    m_word[i] = in_data & (8'hFF >> (8 - wid(i)));
                    m_pos[i]  = 0;
                    m_hs[i]   = m_hs[i] + 1;
                end else if (m_pos[i] >= 0) begin
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == nbits(i) + gapn(i)) m_pos[i] = -1;
                end
            end
        end
    end

    task automatic drain();
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== 5'b00000) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d got %b exp %b", i, obs(i), 5'b00000);
                end
            end
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (obs(i) !== 5'b10000) begin
                errors++;
                $display("FAIL reset_release dut%0d got %b exp %b", i, obs(i), 5'b10000);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_word();
        logic [7:0] w;
        w        = 8'hA5;
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < NB0 + 2; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL single_model dut%0d k=%0d got %b exp %b", i, k, obs(i), expv(i));
                end
            end
            if (k < W0) begin
                checks++;
                if (o_bit[0] !== w[7-k] || o_valid[0] !== 1'b1 || o_done[0] !== (k == NB0 - 1)) begin
                    errors++;
                    $display("FAIL single_a5 k=%0d got bit%b v%b d%b exp bit%b v1 d%b",
                             k, o_bit[0], o_valid[0], o_done[0], w[7-k], (k == NB0 - 1));
                end
            end
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [2*NB0-1:0] exp_stream;
        logic [2*NB0-1:0] got_stream;
`ifdef SER_PARITY_EN
        exp_stream = {8'hAA, ^8'hAA, 8'h55, ^8'h55};
`else
        exp_stream = {8'hAA, 8'h55};
`endif
        got_stream = '0;
        in_data    = 8'hAA;
        in_valid   = 1'b1;
        for (int k = 1; k <= 2 * NB0; k++) begin
            @(negedge clk);
            if (k == 1)       in_data  = 8'h55;
            if (k == NB0 + 1) in_valid = 1'b0;
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d k=%0d got %b exp %b", i, k, obs(i), expv(i));
                end
            end
            checks++;
            if (o_valid[0] !== 1'b1 || o_ready[0] !== (k == NB0 || k == 2 * NB0)) begin
                errors++;
                $display("FAIL b2b_flow k=%0d got v%b r%b exp v1 r%b",
                         k, o_valid[0], o_ready[0], (k == NB0 || k == 2 * NB0));
            end
            got_stream[2*NB0-k] = o_bit[0];
        end
        checks++;
        if (got_stream !== exp_stream) begin
            errors++;
            $display("FAIL b2b_stream got %b exp %b", got_stream, exp_stream);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_gap();
        int base, phase, gap_cnt, idle_cnt;
        base     = m_hs[1];
        phase    = 0;
        gap_cnt  = 0;
        idle_cnt = 0;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k < 3 * NB0 + 8; k++) begin
            @(negedge clk);
            if (k == 0) in_data = 8'hE1;
            if (m_hs[1] - base >= 2) in_valid = 1'b0;
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL gap_model dut%0d k=%0d got %b exp %b", i, k, obs(i), expv(i));
                end
            end
            if (phase == 0 && o_done[1]) begin
                phase = 1;
            end else if (phase == 1) begin
                if (o_valid[1]) phase = 2;
                else if (o_busy[1] && !o_ready[1]) gap_cnt++;
                else if (!o_busy[1] && o_ready[1]) idle_cnt++;
            end
        end
        checks++;
        if (phase != 2 || gap_cnt != G1 || idle_cnt != 1) begin
            errors++;
            $display("FAIL gap_spacing got phase%0d gap%0d idle%0d exp phase2 gap%0d idle1",
                     phase, gap_cnt, idle_cnt, G1);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midword();
        logic [7:0] got;
        in_data  = 8'h96;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        // dut_a is now presenting bit 3 of the word
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (obs(i) !== 5'b00000 || expv(i) !== 5'b00000) begin
                errors++;
                $display("FAIL reset_async dut%0d got %b exp %b", i, obs(i), 5'b00000);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        in_data  = 8'hF0;
        in_valid = 1'b1;
        got      = 8'h00;
        for (int k = 0; k < W0; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL rst_reload_model dut%0d k=%0d got %b exp %b", i, k, obs(i), expv(i));
                end
            end
            got[7-k] = o_bit[0] & o_valid[0];
        end
        checks++;
        if (got !== 8'hF0) begin
            errors++;
            $display("FAIL rst_reload_bits got %b exp %b", got, 8'hF0);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_parity_tail();
        logic [7:0] words [2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        for (int n = 0; n < 2; n++) begin
            in_data  = words[n];
            in_valid = 1'b1;
            for (int k = 0; k < NB0 + 1; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                for (int i = 0; i < ND; i++) begin
                    checks++;
                    if (obs(i) !== expv(i)) begin
                        errors++;
                        $display("FAIL tail_model dut%0d k=%0d got %b exp %b", i, k, obs(i), expv(i));
                    end
                end
`ifdef SER_PARITY_EN
                if (k == W0) begin
                    checks++;
                    if (o_valid[0] !== 1'b1 || o_done[0] !== 1'b1 || o_bit[0] !== (n == 0)) begin
                        errors++;
                        $display("FAIL parity_bit w=%h got v%b d%b b%b exp v1 d1 b%b",
                                 words[n], o_valid[0], o_done[0], o_bit[0], (n == 0));
                    end
                end
`else
                if (k == W0) begin
                    checks++;
                    if (o_valid[0] !== 1'b0 || o_done[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL no_parity_tail w=%h got v%b d%b exp v0 d0",
                                 words[n], o_valid[0], o_done[0]);
                    end
                end
`endif
            end
            drain();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_idle();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== 5'b10000 || expv(i) !== 5'b10000) begin
                    errors++;
                    $display("FAIL idle dut%0d k=%0d got %b exp %b", i, k, obs(i), 5'b10000);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = 1'b1;
            in_valid = ($urandom_range(0, 9) < 6);
            in_data  = 8'($urandom);
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random dut%0d c=%0d got %b exp %b", i, c, obs(i), expv(i));
                end
            end
            if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                for (int i = 0; i < ND; i++) begin
                    checks++;
                    if (obs(i) !== expv(i)) begin
                        errors++;
                        $display("FAIL random_rst dut%0d c=%0d got %b exp %b", i, c, obs(i), expv(i));
                    end
                end
            end
        end
        rst = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_gap();
        test_reset_midword();
        test_parity_tail();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
